// File: rtl/decode_sequencer.sv
// E0C6S46 instruction decode and step sequencer: decodes accepted opcodes to a
// microcode start address and length class, then counts steps under step_en.
package decode_sequencer_pkg;
    typedef enum logic [1:0] {
        CYCLE5  = 2'd0,
        CYCLE7  = 2'd1,
        CYCLE12 = 2'd2
    } instr_length;
endpackage

module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter int unsigned MICROCODE_ADDR_WIDTH = 7,
    parameter int unsigned STEP_WIDTH           = 4,
    parameter int unsigned CYCLE5_LEN           = 5,
    parameter int unsigned CYCLE7_LEN           = 7,
    parameter int unsigned CYCLE12_LEN          = 12,
    parameter int unsigned PSET_ADDR            = 10,
    parameter int unsigned UNIMPL_ADDR          = 127
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            step_en,
    input  logic [11:0]                     opcode,
    input  logic                            opcode_valid,
    output logic                            opcode_ready,
    output logic [MICROCODE_ADDR_WIDTH-1:0] microcode_addr,
    output instr_length                     cycle_length,
    output logic [STEP_WIDTH-1:0]           step,
    output logic                            busy,
    output logic [7:0]                      immed,
    output logic                            instr_done,
    output logic                            pc_increment,
    output logic                            np_valid,
    output logic [4:0]                      np_bank,
    output logic                            irq_block,
    output logic                            illegal
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [STEP_WIDTH-1:0]           step_q, step_d;
    logic [MICROCODE_ADDR_WIDTH-1:0] addr_q, addr_d;
    instr_length                     len_q, len_d;
    logic [7:0]                      immed_q, immed_d;
    logic                            skip_q, skip_d;
    logic                            illegal_q, illegal_d;
    logic                            is_pset_q, is_pset_d;
    logic                            np_valid_q, np_valid_d;
    logic [4:0]                      np_bank_q, np_bank_d;

    logic [MICROCODE_ADDR_WIDTH-1:0] dec_addr;
    instr_length                     dec_len;
    logic                            dec_skip;
    logic                            dec_illegal;
    logic                            dec_pset;
    logic [STEP_WIDTH-1:0]           last_step;
    logic                            last;
    logic                            accept;

    always_comb begin
        dec_addr    = MICROCODE_ADDR_WIDTH'(UNIMPL_ADDR);
        dec_len     = CYCLE5;
        dec_skip    = 1'b0;
        dec_illegal = 1'b1;
        dec_pset    = 1'b0;
        if (opcode[11:5] == 7'b1110010) begin
            dec_addr    = MICROCODE_ADDR_WIDTH'(PSET_ADDR);
            dec_illegal = 1'b0;
            dec_pset    = 1'b1;
        end else if (opcode[11:8] <= 4'd9) begin
            // Opcodes 0..9 map their high nibble straight to the start address.
            dec_addr    = MICROCODE_ADDR_WIDTH'(opcode[11:8]);
            dec_illegal = 1'b0;
            case (opcode[11:8])
                4'd1: begin
                    dec_len  = CYCLE12;
                    dec_skip = 1'b1;
                end
                4'd4, 4'd5: begin
                    dec_len  = CYCLE7;
                    dec_skip = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (len_q)
            CYCLE7:  last_step = STEP_WIDTH'(CYCLE7_LEN - 1);
            CYCLE12: last_step = STEP_WIDTH'(CYCLE12_LEN - 1);
            default: last_step = STEP_WIDTH'(CYCLE5_LEN - 1);
        endcase
    end

    assign last         = (state_q == EXEC) && (step_q == last_step);
    assign opcode_ready = !reset && step_en && ((state_q == IDLE) || last);
    assign accept       = opcode_valid && opcode_ready;
    assign instr_done   = !reset && last && step_en;
    assign pc_increment = instr_done && !skip_q;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        addr_d     = addr_q;
        len_d      = len_q;
        immed_d    = immed_q;
        skip_d     = skip_q;
        illegal_d  = illegal_q;
        is_pset_d  = is_pset_q;
        np_valid_d = np_valid_q;
        np_bank_d  = np_bank_q;

        if (accept) begin
            state_d   = EXEC;
            step_d    = '0;
            addr_d    = dec_addr;
            len_d     = dec_len;
            immed_d   = opcode[7:0];
            skip_d    = dec_skip;
            illegal_d = dec_illegal;
            is_pset_d = dec_pset;
        end else if ((state_q == EXEC) && step_en) begin
            if (last) begin
                state_d = IDLE;
                step_d  = '0;
            end else begin
                step_d = step_q + 1'b1;
            end
        end

        // The prefix belongs to the completing instruction, which immed_q still holds.
        if (instr_done) begin
            if (is_pset_q) begin
                np_valid_d = 1'b1;
                np_bank_d  = immed_q[4:0];
            end else begin
                np_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            addr_q     <= '0;
            len_q      <= CYCLE5;
            immed_q    <= '0;
            skip_q     <= 1'b0;
            illegal_q  <= 1'b0;
            is_pset_q  <= 1'b0;
            np_valid_q <= 1'b0;
            np_bank_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            immed_q    <= immed_d;
            skip_q     <= skip_d;
            illegal_q  <= illegal_d;
            is_pset_q  <= is_pset_d;
            np_valid_q <= np_valid_d;
            np_bank_q  <= np_bank_d;
        end
    end

    assign microcode_addr = addr_q;
    assign cycle_length   = len_q;
    assign step           = step_q;
    assign busy           = (state_q == EXEC);
    assign immed          = immed_q;
    assign illegal        = illegal_q;
    assign np_valid       = np_valid_q;
    assign np_bank        = np_bank_q;
    assign irq_block      = np_valid_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: decode expectations are queued at
// accept and compared the cycle the decoded fields appear.
module tb_decode_sequencer;
    import decode_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_en;
    logic [11:0] opcode;
    logic        opcode_valid;
    logic        opcode_ready;
    logic [6:0]  microcode_addr;
    instr_length cycle_length;
    logic [3:0]  step;
    logic        busy;
    logic [7:0]  immed;
    logic        instr_done;
    logic        pc_increment;
    logic        np_valid;
    logic [4:0]  np_bank;
    logic        irq_block;
    logic        illegal;

    decode_sequencer #(
        .MICROCODE_ADDR_WIDTH(7),
        .STEP_WIDTH(4),
        .CYCLE5_LEN(5),
        .CYCLE7_LEN(7),
        .CYCLE12_LEN(12),
        .PSET_ADDR(10),
        .UNIMPL_ADDR(127)
    ) dut (
        .clk(clk),
        .reset(reset),
        .step_en(step_en),
        .opcode(opcode),
        .opcode_valid(opcode_valid),
        .opcode_ready(opcode_ready),
        .microcode_addr(microcode_addr),
        .cycle_length(cycle_length),
        .step(step),
        .busy(busy),
        .immed(immed),
        .instr_done(instr_done),
        .pc_increment(pc_increment),
        .np_valid(np_valid),
        .np_bank(np_bank),
        .irq_block(irq_block),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        instr_length len;
        logic [7:0]  immed;
        logic        skip;
        logic        illegal;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic exp_t model(input logic [11:0] op);
        exp_t e;
        e.immed   = op[7:0];
        e.skip    = 1'b0;
        e.illegal = 1'b0;
        e.len     = CYCLE5;
        e.n       = 5;
        if (op[11:8] <= 4'd9) e.addr = {3'b000, op[11:8]};
        else if (op[11:5] == 7'h72) e.addr = 7'd10;
        else begin
            e.addr    = 7'd127;
            e.illegal = 1'b1;
        end
        if (op[11:8] == 4'd1) begin
            e.len = CYCLE12; e.n = 12; e.skip = 1'b1;
        end else if (op[11:8] == 4'd4 || op[11:8] == 4'd5) begin
            e.len = CYCLE7; e.n = 7; e.skip = 1'b1;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; step_en = 1'b1; opcode_valid = 1'b0; opcode = '0;
        tick();
        #1;
        checks++;
        if ({opcode_ready, instr_done, pc_increment} !== 3'b000) begin
            fails++;
            $display("FAIL reset_comb: ready/done/pc=%b expected 000", {opcode_ready, instr_done, pc_increment});
        end
        tick();
        checks++;
        if ({busy, step, microcode_addr, cycle_length, immed, illegal, np_valid, np_bank, irq_block} !==
            {1'b0, 4'd0, 7'd0, CYCLE5, 8'd0, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: busy=%b step=%0d addr=%0d len=%0d immed=%h ill=%b npv=%b npb=%h irq=%b expected all zero",
                     busy, step, microcode_addr, cycle_length, immed, illegal, np_valid, np_bank, irq_block);
        end
        reset = 1'b0;
    endtask

    task automatic test_instr(input logic [11:0] op);
        exp_t e;
        logic exp_done, exp_pc;
        opcode = op; opcode_valid = 1'b1; step_en = 1'b1;
        #1;
        checks++;
        if (opcode_ready !== 1'b1) begin
            fails++; $display("FAIL instr_accept op=%h: ready=%b expected 1", op, opcode_ready);
        end
        sb.push_back(model(op));
        tick();
        opcode_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({microcode_addr, cycle_length, immed, illegal, busy, step} !== {e.addr, e.len, e.immed, e.illegal, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL instr_decode op=%h: addr=%0d len=%0d immed=%h ill=%b busy=%b step=%0d expected addr=%0d len=%0d immed=%h ill=%b busy=1 step=0",
                     op, microcode_addr, cycle_length, immed, illegal, busy, step, e.addr, e.len, e.immed, e.illegal);
        end
        for (int k = 0; k < e.n; k++) begin
            checks++;
            if (step !== 4'(k) || busy !== 1'b1) begin
                fails++; $display("FAIL instr_step op=%h: step=%0d busy=%b expected step=%0d busy=1", op, step, busy, k);
            end
            #1;
            exp_done = (k == e.n - 1);
            exp_pc   = exp_done && !e.skip;
            checks++;
            if ({instr_done, pc_increment} !== {exp_done, exp_pc}) begin
                fails++;
                $display("FAIL instr_done op=%h k=%0d: done/pc=%b%b expected %b%b", op, k, instr_done, pc_increment, exp_done, exp_pc);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || step !== 4'd0) begin
            fails++; $display("FAIL instr_idle op=%h: busy=%b step=%0d expected 0 0", op, busy, step);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        opcode = 12'h400; opcode_valid = 1'b1; step_en = 1'b1;
        #1;
        checks++;
        if (opcode_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_accept: ready=%b expected 1", opcode_ready);
        end
        sb.push_back(model(12'h400));
        tick();
        opcode = 12'h2FF;
        e = sb.pop_front();
        checks++;
        if ({microcode_addr, cycle_length, immed} !== {e.addr, e.len, e.immed}) begin
            fails++; $display("FAIL b2b_call_decode: addr=%0d len=%0d immed=%h expected %0d %0d %h",
                              microcode_addr, cycle_length, immed, e.addr, e.len, e.immed);
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (step !== 4'(k) || busy !== 1'b1) begin
                fails++; $display("FAIL b2b_call_step: step=%0d busy=%b expected %0d 1", step, busy, k);
            end
            #1;
            checks++;
            if ({opcode_ready, instr_done, pc_increment} !== {k == 6, k == 6, 1'b0}) begin
                fails++; $display("FAIL b2b_call_ctl k=%0d: ready/done/pc=%b%b%b expected %b%b0",
                                  k, opcode_ready, instr_done, pc_increment, k == 6, k == 6);
            end
            if (k == 6) sb.push_back(model(12'h2FF));
            tick();
        end
        opcode_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({microcode_addr, cycle_length, immed, step, busy} !== {e.addr, e.len, e.immed, 4'd0, 1'b1}) begin
            fails++; $display("FAIL b2b_jp_decode: addr=%0d len=%0d immed=%h step=%0d busy=%b expected %0d %0d %h 0 1",
                              microcode_addr, cycle_length, immed, step, busy, e.addr, e.len, e.immed);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (step !== 4'(k) || busy !== 1'b1) begin
                fails++; $display("FAIL b2b_jp_step: step=%0d busy=%b expected %0d 1", step, busy, k);
            end
            #1;
            checks++;
            if ({instr_done, pc_increment} !== {k == 4, k == 4}) begin
                fails++; $display("FAIL b2b_jp_done k=%0d: done/pc=%b%b expected %b%b", k, instr_done, pc_increment, k == 4, k == 4);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL b2b_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_step_en_toggle();
        exp_t e;
        int   exp_step = 0;
        logic done_seen = 1'b0;
        logic exp_done;
        opcode = 12'h0A7; opcode_valid = 1'b1; step_en = 1'b1;
        #1;
        checks++;
        if (opcode_ready !== 1'b1) begin
            fails++; $display("FAIL toggle_accept: ready=%b expected 1", opcode_ready);
        end
        sb.push_back(model(12'h0A7));
        tick();
        opcode_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({microcode_addr, cycle_length, immed} !== {e.addr, e.len, e.immed}) begin
            fails++; $display("FAIL toggle_decode: addr=%0d len=%0d immed=%h expected %0d %0d %h",
                              microcode_addr, cycle_length, immed, e.addr, e.len, e.immed);
        end
        for (int c = 0; c < 12; c++) begin
            step_en = (c % 2 == 0);
            checks++;
            if (step !== 4'(exp_step) || busy !== !done_seen) begin
                fails++; $display("FAIL toggle_step c=%0d: step=%0d busy=%b expected %0d %b", c, step, busy, exp_step, !done_seen);
            end
            #1;
            exp_done = step_en && !done_seen && (exp_step == e.n - 1);
            checks++;
            if (instr_done !== exp_done) begin
                fails++; $display("FAIL toggle_done c=%0d: done=%b expected %b", c, instr_done, exp_done);
            end
            if (step_en && !done_seen) begin
                if (exp_step == e.n - 1) begin
                    done_seen = 1'b1;
                    exp_step  = 0;
                end else begin
                    exp_step++;
                end
            end
            tick();
        end
        step_en = 1'b1;
    endtask

    task automatic test_pset();
        exp_t e;
        opcode = 12'hE53; opcode_valid = 1'b1; step_en = 1'b1;
        #1;
        sb.push_back(model(12'hE53));
        tick();
        opcode_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({microcode_addr, cycle_length, immed, illegal} !== {e.addr, e.len, e.immed, e.illegal}) begin
            fails++; $display("FAIL pset_decode: addr=%0d len=%0d immed=%h ill=%b expected %0d %0d %h %b",
                              microcode_addr, cycle_length, immed, illegal, e.addr, e.len, e.immed, e.illegal);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (np_valid !== 1'b0) begin
                fails++; $display("FAIL pset_early k=%0d: np_valid=%b expected 0", k, np_valid);
            end
            #1;
            checks++;
            if (instr_done !== (k == 4)) begin
                fails++; $display("FAIL pset_done k=%0d: done=%b expected %b", k, instr_done, k == 4);
            end
            tick();
        end
        checks++;
        if ({np_valid, np_bank, irq_block} !== {1'b1, 5'h13, 1'b1}) begin
            fails++; $display("FAIL pset_set: np_valid=%b np_bank=%h irq=%b expected 1 13 1", np_valid, np_bank, irq_block);
        end
        opcode = 12'h010; opcode_valid = 1'b1;
        #1;
        sb.push_back(model(12'h010));
        tick();
        opcode_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (microcode_addr !== e.addr) begin
            fails++; $display("FAIL pset_jp_decode: addr=%0d expected %0d", microcode_addr, e.addr);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (np_valid !== 1'b1 || irq_block !== 1'b1) begin
                fails++; $display("FAIL pset_hold k=%0d: np_valid=%b irq=%b expected 1 1", k, np_valid, irq_block);
            end
            #1;
            tick();
        end
        checks++;
        if ({np_valid, np_bank, irq_block} !== {1'b0, 5'h13, 1'b0}) begin
            fails++; $display("FAIL pset_clear: np_valid=%b np_bank=%h irq=%b expected 0 13 0", np_valid, np_bank, irq_block);
        end
    endtask

    task automatic test_illegal_reset();
        exp_t e;
        opcode = 12'hA00; opcode_valid = 1'b1; step_en = 1'b1;
        #1;
        sb.push_back(model(12'hA00));
        tick();
        opcode_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({microcode_addr, cycle_length, illegal} !== {e.addr, e.len, e.illegal}) begin
            fails++; $display("FAIL illegal_decode: addr=%0d len=%0d ill=%b expected %0d %0d %b",
                              microcode_addr, cycle_length, illegal, e.addr, e.len, e.illegal);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (step !== 4'(k)) begin
                fails++; $display("FAIL illegal_step: step=%0d expected %0d", step, k);
            end
            if (k == 2) reset = 1'b1;
            #1;
            checks++;
            if (instr_done !== 1'b0) begin
                fails++; $display("FAIL illegal_nodone k=%0d: done=%b expected 0", k, instr_done);
            end
            tick();
        end
        checks++;
        if ({busy, step, illegal} !== {1'b0, 4'd0, 1'b0}) begin
            fails++; $display("FAIL illegal_reset: busy=%b step=%0d ill=%b expected 0 0 0", busy, step, illegal);
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (instr_done !== 1'b0 || busy !== 1'b0) begin
                fails++; $display("FAIL illegal_after c=%0d: done=%b busy=%b expected 0 0", c, instr_done, busy);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_instr(12'h8A5);
        test_instr(12'h123);
        test_back_to_back();
        test_step_en_toggle();
        test_pset();
        test_illegal_reset();
        checks++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
